// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   state_t : arbiter FSM encoding (IDLE -> CMD -> RESP)
//   REQ_CPU : requester index of the CPU data port
//   REQ_DBG : requester index of the debug/loader port
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-requester winner selection (purely combinational).
//   req[1:0]   : request vector, bit i = requester i
//   last_owner : requester served by the most recent command
//   lock       : debug port burst lock
//   valid      : at least one eligible requester
//   winner     : index of the selected requester
// FIXED_PRIO=1 makes the CPU win every tie; 0 alternates on ties.
module rr_pick2
  import dmem_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic [1:0] req,
  input  logic       last_owner,
  input  logic       lock,
  output logic       valid,
  output logic       winner
);

  logic [1:0] eligible;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    eligible = req;
    // A held lock keeps ownership with the debug port once it has it; the
    // CPU is masked out even if the debug port is momentarily not requesting.
    if (lock && (last_owner == REQ_DBG)) begin
      eligible = {req[1], 1'b0};
    end

    valid  = |eligible;
    winner = REQ_CPU;
    if (eligible == 2'b11) begin
      winner = FIXED_PRIO ? REQ_CPU : ~last_owner;
    end else if (eligible[1]) begin
      winner = REQ_DBG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a single-port data memory between the CPU data port (m0) and a
// debug/loader port (m1).
//   clk, rst          : clock, asynchronous active-low reset
//   m0_*              : CPU requester (req/we/addr/wdata in, gnt/rvalid/rdata out)
//   m1_*              : debug requester, plus m1_lock to hold a burst
//   mem_read/mem_write: one-cycle memory strobes, only in CMD
//   mem_addr/mem_wdata: command driven to memory
//   mem_rdata         : combinational read data of mem_addr
// A request seen in cycle N is granted (with the memory strobe) in N+1 and a
// read returns rvalid in N+2; a new decision is taken in RESP, so back-to-back
// commands issue every two cycles.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,

  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state_q, state_d;
  logic              last_owner_q, last_owner_d;
  logic              cmd_owner_q, cmd_owner_d;
  logic              cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic pick_valid;
  logic pick_winner;
  logic decide;

  rr_pick2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_pick (
    .req        ({m1_req, m0_req}),
    .last_owner (last_owner_q),
    .lock       (m1_lock),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  // Decisions are taken in IDLE and RESP; CMD is always followed by RESP.
  assign decide = (state_q == IDLE) || (state_q == RESP);

  // ---------------------------------------------------------------- state reg
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE, RESP: state_d = pick_valid ? CMD : IDLE;
      CMD:        state_d = RESP;
      default:    state_d = IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    mem_read  = (state_q == CMD) && !cmd_we_q;
    mem_write = (state_q == CMD) &&  cmd_we_q;
    mem_addr  = cmd_addr_q;
    mem_wdata = cmd_wdata_q;
    m0_gnt    = (state_q == CMD)  && (cmd_owner_q == REQ_CPU);
    m1_gnt    = (state_q == CMD)  && (cmd_owner_q == REQ_DBG);
    m0_rvalid = (state_q == RESP) && !cmd_we_q && (cmd_owner_q == REQ_CPU);
    m1_rvalid = (state_q == RESP) && !cmd_we_q && (cmd_owner_q == REQ_DBG);
    m0_rdata  = rdata0_q;
    m1_rdata  = rdata1_q;
  end

  // ----------------------------------------------------------------- datapath
  always_comb begin
    last_owner_d = last_owner_q;
    cmd_owner_d  = cmd_owner_q;
    cmd_we_d     = cmd_we_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;

    // The command is captured at decision time, so later changes on the
    // requester inputs (including a dropped req) do not affect it.
    if (decide && pick_valid) begin
      cmd_owner_d = pick_winner;
      if (pick_winner == REQ_DBG) begin
        cmd_we_d    = m1_we;
        cmd_addr_d  = m1_addr;
        cmd_wdata_d = m1_wdata;
      end else begin
        cmd_we_d    = m0_we;
        cmd_addr_d  = m0_addr;
        cmd_wdata_d = m0_wdata;
      end
    end

    if (state_q == CMD) begin
      last_owner_d = cmd_owner_q;
      if (!cmd_we_q) begin
        if (cmd_owner_q == REQ_DBG) rdata1_d = mem_rdata;
        else                        rdata0_d = mem_rdata;
      end
    end
  end

  // last_owner resets to the debug port so the CPU wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner_q <= REQ_DBG;
      cmd_owner_q  <= REQ_CPU;
      cmd_we_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      last_owner_q <= last_owner_d;
      cmd_owner_q  <= cmd_owner_d;
      cmd_we_q     <= cmd_we_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter. Instance u_rr is round-robin, u_fp has
// FIXED_PRIO=1; both see the same requester stimulus and each has its own
// behavioural memory with a combinational read.
module tb_dmem_arbiter;

  localparam int AW = 6;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;

  logic          m0_req = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;

  logic          a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid;
  logic [DW-1:0] a_m0_rdata, a_m1_rdata;
  logic          a_mem_read, a_mem_write;
  logic [AW-1:0] a_mem_addr;
  logic [DW-1:0] a_mem_wdata, a_mem_rdata;

  logic          b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid;
  logic [DW-1:0] b_m0_rdata, b_m1_rdata;
  logic          b_mem_read, b_mem_write;
  logic [AW-1:0] b_mem_addr;
  logic [DW-1:0] b_mem_wdata, b_mem_rdata;

  logic [DW-1:0] mem_a [0:(1<<AW)-1];
  logic [DW-1:0] mem_b [0:(1<<AW)-1];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign a_mem_rdata = mem_a[a_mem_addr];
  assign b_mem_rdata = mem_b[b_mem_addr];
  always @(posedge clk) if (a_mem_write) mem_a[a_mem_addr] <= a_mem_wdata;
  always @(posedge clk) if (b_mem_write) mem_b[b_mem_addr] <= b_mem_wdata;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b0)) u_rr (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock),
    .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b1)) u_fp (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock),
    .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on the round-robin instance, requested in the
  // current cycle; returns in the RESP cycle (a decision cycle).
  task automatic issue(input bit port, input bit we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input logic [DW-1:0] exp_rdata,
                       input string tag);
    if (port) begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wd;
    end else begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wd;
    end
    tick();
    check({tag, "_gnt"},    port ? a_m1_gnt : a_m0_gnt, 1);
    check({tag, "_ogn"},    port ? a_m0_gnt : a_m1_gnt, 0);
    check({tag, "_mrd"},    a_mem_read, !we);
    check({tag, "_mwr"},    a_mem_write, we);
    check({tag, "_maddr"},  a_mem_addr, addr);
    if (we) check({tag, "_mwdata"}, a_mem_wdata, wd);
    if (port) m1_req = 1'b0; else m0_req = 1'b0;
    tick();
    check({tag, "_rvalid"}, port ? a_m1_rvalid : a_m0_rvalid, !we);
    check({tag, "_orv"},    port ? a_m0_rvalid : a_m1_rvalid, 0);
    check({tag, "_strb"},   {a_mem_read, a_mem_write}, 2'b00);
    if (!we) check({tag, "_rdata"}, port ? a_m1_rdata : a_m0_rdata, exp_rdata);
  endtask

  // Expected {m1,m0} grant / rvalid pattern for cycles N+1..N+8 of the tie test.
  logic [1:0] exp_gnt_rr [1:8] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
  logic [1:0] exp_rv_rr  [1:8] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
  logic [1:0] exp_gnt_fp [1:8] = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};

  initial begin
    // ---- reset state
    tick(); tick();
    check("rst_m0_gnt",    a_m0_gnt, 0);
    check("rst_m1_gnt",    a_m1_gnt, 0);
    check("rst_rvalid",    {a_m1_rvalid, a_m0_rvalid}, 2'b00);
    check("rst_strobes",   {a_mem_read, a_mem_write}, 2'b00);
    check("rst_m0_rdata",  a_m0_rdata, 0);
    check("rst_m1_rdata",  a_m1_rdata, 0);
    check("rst_fp_gnt",    {b_m1_gnt, b_m0_gnt}, 2'b00);
    rst = 1'b1;

    // ---- writes by m1 (address 63 and the preload for the read test)
    issue(1'b1, 1'b1, 6'h3F, 32'h0000_00A5, '0, "wr3f");
    tick();
    issue(1'b1, 1'b1, 6'h05, 32'hDEAD_BEEF, '0, "wr05");
    tick();

    // ---- single m0 read
    issue(1'b0, 1'b0, 6'h05, '0, 32'hDEAD_BEEF, "rd05");
    check("rd05_m1_rdata", a_m1_rdata, 0);
    tick();
    check("rd05_rv_drop",  a_m0_rvalid, 0);
    check("rd05_hold",     a_m0_rdata, 32'hDEAD_BEEF);
    issue(1'b0, 1'b0, 6'h3F, '0, 32'h0000_00A5, "rd3f");
    tick();

    // ---- reset during CMD of an m0 read
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 6'h05;
    tick();
    check("rstmid_gnt", a_m0_gnt, 1);
    #2 rst = 1'b0;
    #1;
    check("rstmid_gnt0",   {a_m1_gnt, a_m0_gnt}, 2'b00);
    check("rstmid_strb",   {a_mem_read, a_mem_write}, 2'b00);
    check("rstmid_rdata",  a_m0_rdata, 0);
    m0_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("rstmid_norv", {a_m1_rvalid, a_m0_rvalid}, 2'b00);
    issue(1'b0, 1'b0, 6'h3F, '0, 32'h0000_00A5, "rd_post_rst");
    tick();

    // ---- tie from reset: round-robin alternates, fixed priority keeps m0
    rst = 1'b0;
    tick();
    rst = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 6'h05;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 6'h3F;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("tie_rr_gnt_%0d", i), {a_m1_gnt, a_m0_gnt}, exp_gnt_rr[i]);
      check($sformatf("tie_rr_rv_%0d", i),  {a_m1_rvalid, a_m0_rvalid}, exp_rv_rr[i]);
      check($sformatf("tie_fp_gnt_%0d", i), {b_m1_gnt, b_m0_gnt}, exp_gnt_fp[i]);
      check($sformatf("tie_strb_%0d", i),   a_mem_read & a_mem_write, 0);
      if (exp_rv_rr[i][0]) check($sformatf("tie_rd0_%0d", i), a_m0_rdata, 32'hDEAD_BEEF);
      if (exp_rv_rr[i][1]) check($sformatf("tie_rd1_%0d", i), a_m1_rdata, 32'h0000_00A5);
    end
    m0_req = 1'b0;
    tick();
    check("fp_m1_after_drop", {b_m1_gnt, b_m0_gnt}, 2'b10);
    m1_req = 1'b0;
    tick(); tick();

    // ---- lock burst: m1 writes 0..3 while m0 waits
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 6'h05;
    m1_req = 1'b1; m1_we = 1'b1; m1_lock = 1'b1;
    m1_addr = 6'h00; m1_wdata = 32'h1000_0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("lock_gnt_%0d", i),   {a_m1_gnt, a_m0_gnt}, 2'b10);
      check($sformatf("lock_addr_%0d", i),  a_mem_addr, i);
      check($sformatf("lock_wdata_%0d", i), a_mem_wdata, 32'h1000_0000 + i);
      check($sformatf("lock_wr_%0d", i),    a_mem_write, 1);
      check($sformatf("lock_fp_%0d", i),    {b_m1_gnt, b_m0_gnt}, 2'b10);
      if (i == 3) begin
        m1_lock = 1'b0; m1_req = 1'b0;
      end else begin
        m1_addr = AW'(i + 1); m1_wdata = 32'h1000_0000 + DW'(i + 1);
      end
      tick();
      check($sformatf("lock_m0_wait_%0d", i), a_m0_gnt, 0);
    end
    tick();
    check("unlock_m0_gnt", {a_m1_gnt, a_m0_gnt}, 2'b01);
    m0_req = 1'b0;
    tick();
    check("unlock_m0_rdata", a_m0_rdata, 32'hDEAD_BEEF);
    issue(1'b0, 1'b0, 6'h02, '0, 32'h1000_0002, "rd_burst2");
    issue(1'b1, 1'b1, 6'h10, 32'h0000_0055, '0, "wr10");

    // ---- lock held with no m1 request: m0 stays blocked, IDLE
    m1_lock = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 6'h3F;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("lockidle_gnt_%0d", i), {a_m1_gnt, a_m0_gnt}, 2'b00);
      check($sformatf("lockidle_strb_%0d", i), {a_mem_read, a_mem_write}, 2'b00);
    end
    m1_lock = 1'b0;
    tick();
    check("lockrel_m0_gnt", {a_m1_gnt, a_m0_gnt}, 2'b01);
    m0_req = 1'b0;
    tick();
    check("lockrel_rvalid", a_m0_rvalid, 1);
    check("lockrel_rdata",  a_m0_rdata, 32'h0000_00A5);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The parameter list SHALL be, one per line: ADDR_W, default 6, word address width; DATA_W, default 32, data width; FIXED_PRIO, default 0, where 1 means requester 0 always wins ties and 0 means round-robin.
REQ-002 The clock and reset ports SHALL be: clk, input, 1, single clock; rst, input, 1, asynchronous active-low reset.
REQ-003 The requester 0 (CPU data port) ports SHALL be: m0_req in 1; m0_we in 1; m0_addr in ADDR_W; m0_wdata in DATA_W; m0_gnt out 1; m0_rvalid out 1; m0_rdata out DATA_W.
REQ-004 The requester 1 (debug/loader port) ports SHALL be: m1_req in 1; m1_we in 1; m1_addr in ADDR_W; m1_wdata in DATA_W; m1_lock in 1, which holds ownership for a burst; m1_gnt out 1; m1_rvalid out 1; m1_rdata out DATA_W.
REQ-005 The memory side ports SHALL be: mem_read out 1; mem_write out 1; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_rdata in DATA_W, a combinational read of mem_addr.

Function
REQ-006 The FSM SHALL have exactly three states: IDLE, CMD, RESP.
REQ-007 In IDLE or RESP, the arbiter SHALL choose a winner from the requests present; it SHALL latch that winner's we, addr and wdata into command registers and go to CMD next cycle; with no request it SHALL go to IDLE.
REQ-008 In CMD, the arbiter SHALL drive mem_addr and mem_wdata from the command registers, assert mem_write if we=1 or mem_read if we=0, and pulse gnt for exactly one cycle for the winner only.
REQ-009 In CMD, the arbiter SHALL capture mem_rdata into the winner's rdata register for reads only and go to RESP.
REQ-010 In RESP, the winner's rvalid SHALL pulse for one cycle, for reads only; rdata SHALL hold its value until the next read by that requester.
REQ-011 Latency SHALL be: request seen in cycle N, gnt and memory strobe in N+1, rvalid in N+2; back-to-back transactions SHALL issue one CMD every 2 cycles.
REQ-012 A requester SHALL hold req, we, addr and wdata stable until its gnt; the arbiter SHALL ignore changes to these after latching.
REQ-013 A req deasserted before gnt SHALL still complete, because the command is already latched.
REQ-014 Tie-break SHALL follow this rule: with FIXED_PRIO=0, the requester not in last_owner wins; with FIXED_PRIO=1, requester 0 wins.
REQ-015 last_owner SHALL update on every CMD.
REQ-016 Lock SHALL follow this rule: when m1_lock=1 and last_owner=1, only m1_req is eligible and m0 waits regardless of priority; when m1_lock=0, normal arbitration resumes at the next decision.
REQ-017 Lock with m1_req=0 SHALL NOT grant m1; the arbiter SHALL stay in IDLE, with m0 still blocked.
REQ-018 mem_read and mem_write SHALL never both be 1, and both SHALL be 0 outside CMD.
REQ-019 gnt and rvalid SHALL be one-hot across requesters, or zero.

Reset
REQ-020 While rst=0, the arbiter SHALL asynchronously set state=IDLE, last_owner=1 (so m0 wins the first tie), clear all command registers, and drive every gnt, rvalid, mem_read and mem_write to 0 and both rdata to 0.
REQ-021 A reset asserted in CMD or RESP SHALL abort the transaction, with no rvalid afterwards.
REQ-022 Arbitration SHALL resume on the first clk edge after rst returns to 1.

Structure
REQ-023 A shared package SHALL hold the state encoding (IDLE, CMD, RESP) and the requester-index constants REQ_CPU=0 and REQ_DBG=1.
REQ-024 Winner selection SHALL be one combinational sub-module, rr_pick2, with inputs req[1:0], last_owner, lock and FIXED_PRIO and outputs valid and winner.
REQ-025 All other logic SHALL be in dmem_arbiter.

Verification
REQ-026 The bench SHALL cover a single read: m0 read addr 6'h05 with mem[5]=32'hDEADBEEF -> m0_gnt at N+1 with mem_read=1 and mem_addr=5, m0_rvalid at N+2 with m0_rdata=32'hDEADBEEF, m1 outputs 0.
REQ-027 The bench SHALL cover a tie after reset: m0 and m1 both request from reset -> order m0, m1, m0, m1, with CMD in cycles N+1, N+3, N+5, N+7.
REQ-028 The bench SHALL cover a lock burst: m1 writes 4 words to addr 0..3 with m1_lock=1 while m0_req is held -> 4 m1 grants, then m0 granted in the CMD after lock drops.
REQ-029 The bench SHALL cover a write: m1 write addr 6'h3F, data 32'h0000_00A5 -> mem_write=1 for exactly one cycle, no m1_rvalid, mem[63] reads back 32'hA5 by m0.
REQ-030 The bench SHALL cover reset mid-transaction: rst=0 during CMD of an m0 read -> no m0_rvalid, all outputs 0, a fresh m0 request completes with 2-cycle latency.
REQ-031 The bench SHALL cover FIXED_PRIO=1: continuous requests from both -> m0 granted every CMD and m1 never granted until m0_req drops.
